// File: rtl/rxd_freq_pkg.sv
// rtl/rxd_freq_pkg.sv - shared encodings and timing constants for the frequency-coded lock-status link
package rxd_freq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } tx_state_e;

  // Transmit half-periods; the receiver accepts 18..22 and 190..210 cycle periods around them.
  localparam int HALF_1M_DEF   = 10;
  localparam int HALF_100K_DEF = 100;
  localparam int ERR_HALF_DEF  = 50;
  localparam int RX_1M_MIN     = 18;
  localparam int RX_1M_MAX     = 22;
  localparam int RX_100K_MIN   = 190;
  localparam int RX_100K_MAX   = 210;
  localparam int NUM_BRK       = 19999;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic [2:0] lim);
    return (v < lim) ? v + 3'd1 : v;
  endfunction

endpackage

// File: rtl/rxd_freq_tx_halfcnt.sv
// rtl/rxd_freq_tx_halfcnt.sv - half-period counter, restarts at each phase end and while idle
module rxd_freq_tx_halfcnt
  import rxd_freq_pkg::*;
(
  input  logic       clk_20M,
  input  logic       clr,
  input  logic       run,
  input  logic [7:0] half,
  output logic       tc
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tc = run && (cnt_q == half - 8'd1);

  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (!run || tc) cnt_d = 8'd0;
  end

  always_ff @(posedge clk_20M or negedge clr) begin
    if (!clr) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rxd_freq_tx.sv
// rtl/rxd_freq_tx.sv - frequency-coded lock-status transmitter; RXD_FREQ_TX_ERR_INJ_EN enables error periods
module rxd_freq_tx
  import rxd_freq_pkg::*;
#(
  parameter int   HALF_1M     = HALF_1M_DEF,
  parameter int   HALF_100K   = HALF_100K_DEF,
  parameter int   MIN_PERIODS = 2,
  parameter logic IDLE_LEVEL  = 1'b1,
  parameter int   ERR_HALF    = ERR_HALF_DEF
) (
  input  logic clk_20M,
  input  logic clr,
  input  logic tx_en,
  input  logic lock_req,
  input  logic err_inj,
  output logic txd,
  output logic tx_mode,
  output logic period_strobe,
  output logic busy
);

  localparam logic [7:0] H_1M   = 8'(HALF_1M);
  localparam logic [7:0] H_100K = 8'(HALF_100K);
  localparam logic [7:0] H_ERR  = 8'(ERR_HALF);
  localparam logic [2:0] MIN_P  = 3'(MIN_PERIODS);

  tx_state_e  state_q, state_d;
  logic       txd_q, txd_d;
  logic       tx_mode_q, tx_mode_d;
  logic       strobe_q, strobe_d;
  logic       busy_q, busy_d;
  logic [2:0] pc_q, pc_d;
  logic [2:0] pc_inc;
  logic       period_start;
  logic       err_act;
  logic [7:0] half;
  logic       tc;

`ifdef RXD_FREQ_TX_ERR_INJ_EN
  logic err_pend_q, err_pend_d;
  logic err_act_q, err_act_d;

  // A pulse landing on a period start is kept for the following period.
  always_comb begin
    err_act_d  = err_act_q;
    err_pend_d = err_pend_q | err_inj;
    if (period_start) begin
      err_act_d  = err_pend_q;
      err_pend_d = err_inj;
    end
  end

  always_ff @(posedge clk_20M or negedge clr) begin
    if (!clr) begin
      err_pend_q <= 1'b0;
      err_act_q  <= 1'b0;
    end else begin
      err_pend_q <= err_pend_d;
      err_act_q  <= err_act_d;
    end
  end

  assign err_act = err_act_q;
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign err_act        = 1'b0;
`endif

  always_comb half = err_act ? H_ERR : (tx_mode_q ? H_1M : H_100K);

  rxd_freq_tx_halfcnt u_halfcnt (
    .clk_20M (clk_20M),
    .clr     (clr),
    .run     (state_q != ST_IDLE),
    .half    (half),
    .tc      (tc)
  );

  always_comb begin
    state_d      = state_q;
    txd_d        = txd_q;
    tx_mode_d    = tx_mode_q;
    strobe_d     = 1'b0;
    pc_d         = pc_q;
    period_start = 1'b0;
    pc_inc       = err_act ? pc_q : sat_inc3(pc_q, MIN_P);
    case (state_q)
      ST_IDLE: begin
        txd_d = IDLE_LEVEL;
        if (tx_en) begin
          state_d      = ST_HIGH;
          txd_d        = 1'b1;
          strobe_d     = 1'b1;
          tx_mode_d    = lock_req;
          pc_d         = 3'd0;
          period_start = 1'b1;
        end
      end
      ST_HIGH: begin
        if (tc) begin
          state_d = ST_LOW;
          txd_d   = 1'b0;
        end
      end
      ST_LOW: begin
        // Last LOW cycle is the period boundary: the only point where tx_en and lock_req matter.
        if (tc) begin
          pc_d = pc_inc;
          if (!tx_en) begin
            state_d = ST_IDLE;
            txd_d   = IDLE_LEVEL;
          end else begin
            state_d      = ST_HIGH;
            txd_d        = 1'b1;
            strobe_d     = 1'b1;
            period_start = 1'b1;
            if (pc_inc >= MIN_P && lock_req != tx_mode_q) begin
              tx_mode_d = lock_req;
              pc_d      = 3'd0;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_20M or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      txd_q     <= IDLE_LEVEL;
      tx_mode_q <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      pc_q      <= 3'd0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      tx_mode_q <= tx_mode_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      pc_q      <= pc_d;
    end
  end

  assign txd           = txd_q;
  assign tx_mode       = tx_mode_q;
  assign period_strobe = strobe_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rxd_freq_tx.sv
// tb/tb_rxd_freq_tx.sv - self-checking bench for rxd_freq_tx against a period-position reference model
module tb_rxd_freq_tx;

  localparam int MINP  = 2;
  localparam int H1M   = 10;
  localparam int H100K = 100;
  localparam int HERR  = 50;
`ifdef RXD_FREQ_TX_ERR_INJ_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk_20M = 1'b0;
  logic clr = 1'b0;
  logic tx_en = 1'b0;
  logic lock_req = 1'b0;
  logic err_inj = 1'b0;
  logic txd, tx_mode, period_strobe, busy;

  int n_cmp = 0;
  int n_bad = 0;

  rxd_freq_tx dut (
    .clk_20M       (clk_20M),
    .clr           (clr),
    .tx_en         (tx_en),
    .lock_req      (lock_req),
    .err_inj       (err_inj),
    .txd           (txd),
    .tx_mode       (tx_mode),
    .period_strobe (period_strobe),
    .busy          (busy)
  );

  always #25 clk_20M = ~clk_20M;

  // Reference model: whether a period is on the line, position t within it, its mode and error status.
  int m_act, m_t, m_mode, m_cnt, m_pend, m_err;

  function automatic int m_half();
    if (m_err != 0) return HERR;
    return (m_mode != 0) ? H1M : H100K;
  endfunction

  function automatic logic [3:0] m_vec();
    logic l_txd;
    l_txd = (m_act != 0) ? (m_t < m_half()) : 1'b1;
    return {l_txd, m_mode[0], (m_act != 0) && (m_t == 0), m_act[0]};
  endfunction

  always @(posedge clk_20M or negedge clr) begin : model
    bit start;
    int h;
    if (!clr) begin
      m_act = 0; m_t = 0; m_mode = 0; m_cnt = 0; m_pend = 0; m_err = 0;
    end else begin
      start = 1'b0;
      if (m_act == 0) begin
        if (tx_en) begin
          m_act = 1; m_mode = int'(lock_req); m_cnt = 0; start = 1'b1;
        end
      end else begin
        h = m_half();
        m_t++;
        if (m_t == 2 * h) begin
          if (m_err == 0 && m_cnt < MINP) m_cnt++;
          if (!tx_en) m_act = 0;
          else begin
            start = 1'b1;
            if (m_cnt >= MINP && int'(lock_req) != m_mode) begin
              m_mode = int'(lock_req); m_cnt = 0;
            end
          end
        end
      end
      if (start) begin
        m_t = 0;
        m_err  = (ERR_EN && m_pend != 0) ? 1 : 0;
        m_pend = (ERR_EN && err_inj) ? 1 : 0;
      end else begin
        m_pend = (ERR_EN && (m_pend != 0 || err_inj)) ? 1 : 0;
      end
    end
  end

  task automatic test_reset();
    clr = 1'b0; tx_en = 1'b0; lock_req = 1'b0; err_inj = 1'b0;
    repeat (3) @(negedge clk_20M);
    n_cmp++;
    if ({txd, tx_mode, period_strobe, busy} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_state: got %b want %b", {txd, tx_mode, period_strobe, busy}, 4'b1000);
    end
    clr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_20M);
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL reset_idle cyc %0d: got %b want %b", i, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
    end
  endtask

  task automatic test_basic_1m();
    int last;
    tx_en = 1'b1; lock_req = 1'b1;
    @(negedge clk_20M);
    n_cmp++;
    if ({txd, period_strobe, tx_mode} !== 3'b111) begin
      n_bad++; $display("FAIL first_rise: got %b want %b", {txd, period_strobe, tx_mode}, 3'b111);
    end
    last = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk_20M);
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL basic cyc %0d: got %b want %b", i, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
      if (period_strobe) begin
        n_cmp++;
        if (i - last != 20) begin
          n_bad++; $display("FAIL basic_spacing: got %0d want 20", i - last);
        end
        last = i;
      end
    end
  endtask

  task automatic test_switch_100k();
    bit got;
    int run;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk_20M);
      if (period_strobe) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL switch_wait1: got timeout want strobe"); end
    repeat (5) @(negedge clk_20M);
    lock_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk_20M);
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL switch cyc %0d: got %b want %b", i, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
      if (period_strobe) got = 1'b1;
    end
    n_cmp++;
    if (!got || tx_mode !== 1'b0) begin
      n_bad++; $display("FAIL switch_mode_at_strobe: got strobe=%0d mode=%b want strobe=1 mode=0", got, tx_mode);
    end
    run = 0;
    for (int i = 0; i < 300 && txd === 1'b1; i++) begin run++; @(negedge clk_20M); end
    n_cmp++;
    if (run != 100) begin n_bad++; $display("FAIL switch_high_run: got %0d want 100", run); end
    run = 0;
    for (int i = 0; i < 300 && !period_strobe; i++) begin run++; @(negedge clk_20M); end
    n_cmp++;
    if (run != 100) begin n_bad++; $display("FAIL switch_low_run: got %0d want 100", run); end
  endtask

  task automatic test_min_hold();
    int el;
    bit got;
    lock_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 800 && !got; i++) begin @(negedge clk_20M); got = (tx_mode === 1'b1); end
    lock_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clk_20M); got = (tx_mode === 1'b0); end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL hold_wait_100k: got timeout want tx_mode=0"); end
    el = 0;
    for (int i = 0; i < 1000 && tx_mode !== 1'b1; i++) begin
      if (el == 50) lock_req = 1'b1;
      @(negedge clk_20M);
      el++;
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL hold cyc %0d: got %b want %b", el, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
    end
    n_cmp++;
    if (el != 400) begin n_bad++; $display("FAIL hold_duration: got %0d want 400", el); end
    repeat (45) @(negedge clk_20M);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk_20M); got = period_strobe; end
    for (int i = 0; i < 60; i++) begin
      lock_req = !(i >= 3 && i < 8);
      @(negedge clk_20M);
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL glitch cyc %0d: got %b want %b", i, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
    end
    n_cmp++;
    if (tx_mode !== 1'b1) begin n_bad++; $display("FAIL glitch_mode: got %b want 1", tx_mode); end
  endtask

  task automatic test_disable();
    bit got;
    int el;
    lock_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_20M);
      got = (tx_mode === 1'b0) && (period_strobe === 1'b1);
    end
    n_cmp++;
    if (!got) begin n_bad++; $display("FAIL disable_wait: got timeout want 100k strobe"); end
    el = 0;
    for (int i = 0; i < 400 && busy !== 1'b0; i++) begin
      if (el == 2) tx_en = 1'b0;
      @(negedge clk_20M);
      el++;
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL disable cyc %0d: got %b want %b", el, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
    end
    n_cmp++;
    if (el != 200) begin n_bad++; $display("FAIL disable_complete: got %0d want 200", el); end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_20M);
      n_cmp++;
      if ({txd, busy, period_strobe} !== 3'b100) begin
        n_bad++; $display("FAIL idle_hold cyc %0d: got %b want 100", i, {txd, busy, period_strobe});
      end
    end
  endtask

  task automatic test_err_inj();
    bit got;
    int run;
    tx_en = 1'b1; lock_req = 1'b1;
    repeat (50) @(negedge clk_20M);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk_20M); got = period_strobe; end
    @(negedge clk_20M);
    err_inj = 1'b1;
    @(negedge clk_20M);
    err_inj = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk_20M); got = period_strobe; end
    run = 0;
    for (int i = 0; i < 300 && txd === 1'b1; i++) begin run++; @(negedge clk_20M); end
    n_cmp++;
    if (run != (ERR_EN ? HERR : H1M)) begin
      n_bad++; $display("FAIL err_high_run: got %0d want %0d", run, ERR_EN ? HERR : H1M);
    end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_20M);
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL err cyc %0d: got %b want %b", i, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin @(negedge clk_20M); got = (txd === 1'b0) && (busy === 1'b1); end
    #3 clr = 1'b0;
    #1;
    n_cmp++;
    if (!got || {txd, busy} !== 2'b10) begin
      n_bad++; $display("FAIL async_reset: got low_seen=%0d txd/busy=%b want 1 10", got, {txd, busy});
    end
    @(negedge clk_20M);
    clr = 1'b1; tx_en = 1'b1; lock_req = 1'b1;
    @(negedge clk_20M);
    n_cmp++;
    if ({txd, period_strobe, busy} !== 3'b111) begin
      n_bad++; $display("FAIL reset_restart: got %b want 111", {txd, period_strobe, busy});
    end
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_20M);
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL restart cyc %0d: got %b want %b", i, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk_20M);
      n_cmp++;
      if ({txd, tx_mode, period_strobe, busy} !== m_vec()) begin
        n_bad++; $display("FAIL random cyc %0d: got %b want %b", i, {txd, tx_mode, period_strobe, busy}, m_vec());
      end
      if ($urandom_range(39) == 0) lock_req = ~lock_req;
      if (tx_en ? ($urandom_range(299) == 0) : ($urandom_range(29) == 0)) tx_en = ~tx_en;
      err_inj = ($urandom_range(96) == 0);
    end
    err_inj = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_1m();
    test_switch_100k();
    test_min_hold();
    test_disable();
    test_err_inj();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
